// File: rtl/instruction_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : instruction_fetch_queue
//  Purpose  : Front-end fetch stage. Issues one word fetch at a time to
//             instruction memory, queues returned words with their PCs in an
//             in-order circular buffer and hands them to decode one per cycle.
//             Redirects flush the queue and squash any in-flight response.
//  Revision : 1.0  initial release
// ============================================================================
module instruction_fetch_queue #(
  parameter logic [31:0] RESET_ADDRESS = 32'h0000_0000,
  parameter int          DEPTH         = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_enable,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_address,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_address,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        instruction_valid,
  input  logic        instruction_ready,
  output logic [31:0] instruction,
  output logic [31:0] instruction_pc,
  output logic        fetch_misaligned
);

  localparam int                  c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int                  c_CNT_W = c_PTR_W + 1;
  localparam logic [c_CNT_W-1:0]  c_FULL  = c_CNT_W'(DEPTH);
  localparam logic [31:0]         c_NOP   = 32'h0000_0013;

  // Fetch control state
  logic [31:0]        r_pc;
  logic [31:0]        r_req_pc;
  logic               r_outstanding;
  logic               r_drop;
  logic               r_misaligned;
  // A request that was driven but not yet accepted must stay on the bus with
  // its original address, even if a redirect moves r_pc in the meantime.
  logic               r_hold;
  logic [31:0]        r_hold_addr;
  logic               r_hold_redir;

  // Queue state
  logic [c_PTR_W-1:0] r_head;
  logic [c_PTR_W-1:0] r_tail;
  logic [c_CNT_W-1:0] r_count;
  logic [31:0]        r_pc_q   [DEPTH];
  logic [31:0]        r_word_q [DEPTH];

  logic               w_req_new;
  logic               w_req_valid;
  logic [31:0]        w_req_addr;
  logic               w_accept;
  logic               w_resp;
  logic               w_push;
  logic               w_pop;
  logic               w_inst_valid;
  logic               w_outstanding_nxt;
  logic               w_hold_nxt;

  // New requests only from registered state, fetch_enable and redirect, so
  // instruction_ready never reaches the request channel combinationally.
  assign w_req_new   = fetch_enable & ~r_outstanding & (r_count < c_FULL) &
                       ~r_misaligned & ~redirect_valid & ~r_hold;
  assign w_req_valid = r_hold | w_req_new;
  assign w_req_addr  = r_hold ? r_hold_addr : r_pc;
  assign w_accept    = w_req_valid & imem_req_ready;

  // Responses only count while a request is in flight.
  assign w_resp       = imem_resp_valid & r_outstanding;
  assign w_push       = w_resp & ~r_drop & ~redirect_valid;
  assign w_inst_valid = (r_count != '0);
  assign w_pop        = w_inst_valid & instruction_ready & ~redirect_valid;

  // Acceptance and completion never coincide: acceptance needs r_outstanding=0.
  assign w_outstanding_nxt = w_accept | (r_outstanding & ~imem_resp_valid);
  assign w_hold_nxt        = w_req_valid & ~imem_req_ready;

  // Fetch PC, outstanding request tracking, squash flag and misalignment flag
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc          <= RESET_ADDRESS;
      r_req_pc      <= RESET_ADDRESS;
      r_outstanding <= 1'b0;
      r_drop        <= 1'b0;
      r_misaligned  <= 1'b0;
      r_hold        <= 1'b0;
      r_hold_addr   <= RESET_ADDRESS;
      r_hold_redir  <= 1'b0;
    end else begin
      r_outstanding <= w_outstanding_nxt;
      r_hold        <= w_hold_nxt;
      r_hold_addr   <= w_req_addr;

      // Remember that a parked request belongs to a flushed stream so its
      // eventual acceptance does not advance the redirected PC.
      if (!w_hold_nxt) begin
        r_hold_redir <= 1'b0;
      end else if (redirect_valid) begin
        r_hold_redir <= 1'b1;
      end

      if (w_accept) begin
        r_req_pc <= w_req_addr;
      end

      if (redirect_valid) begin
        r_pc <= redirect_address;
      end else if (w_accept && !(r_hold && r_hold_redir)) begin
        r_pc <= r_pc + 32'd4;
      end

      // Any request alive past a redirect (in flight or still parked on the
      // bus) returns a word from the old stream that must be discarded.
      if (redirect_valid) begin
        r_drop <= w_outstanding_nxt | w_hold_nxt;
      end else if (w_resp && r_drop) begin
        r_drop <= 1'b0;
      end

      if (redirect_valid) begin
        r_misaligned <= |redirect_address[1:0];
      end
    end
  end

  // Queue pointers and occupancy; a redirect flushes by snapping head to tail
  always_ff @(posedge clk) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (redirect_valid) begin
      r_head  <= r_tail;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_tail <= r_tail + c_PTR_W'(1);
      end
      if (w_pop) begin
        r_head <= r_head + c_PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Queue storage; contents are qualified by r_count so no reset is needed
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_q[r_tail]   <= r_req_pc;
      r_word_q[r_tail] <= imem_resp_data;
    end
  end

  assign imem_req_valid    = w_req_valid;
  assign imem_req_address  = w_req_addr;
  assign instruction_valid = w_inst_valid;
  assign instruction       = w_inst_valid ? r_word_q[r_head] : c_NOP;
  assign instruction_pc    = w_inst_valid ? r_pc_q[r_head]   : 32'h0000_0000;
  assign fetch_misaligned  = r_misaligned;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instruction_fetch_queue
//  Purpose  : Randomized self-checking bench for instruction_fetch_queue.
//             The reference model tags every request with a stream epoch
//             (bumped on redirect/reset); a response is kept only when its
//             epoch is still current, and kept words sit in an ideal queue.
//  Revision : 1.0  initial release
// ============================================================================
module tb_instruction_fetch_queue;

  localparam logic [31:0] RST_ADDR = 32'h0000_0100;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_enable;
  logic        redirect_valid;
  logic [31:0] redirect_address;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_address;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        instruction_valid;
  logic        instruction_ready;
  logic [31:0] instruction;
  logic [31:0] instruction_pc;
  logic        fetch_misaligned;

  always #5 clk = ~clk;

  instruction_fetch_queue #(
    .RESET_ADDRESS(RST_ADDR),
    .DEPTH        (DEPTH)
  ) u_dut (
    .clk              (clk),
    .reset            (reset),
    .fetch_enable     (fetch_enable),
    .redirect_valid   (redirect_valid),
    .redirect_address (redirect_address),
    .imem_req_valid   (imem_req_valid),
    .imem_req_ready   (imem_req_ready),
    .imem_req_address (imem_req_address),
    .imem_resp_valid  (imem_resp_valid),
    .imem_resp_data   (imem_resp_data),
    .instruction_valid(instruction_valid),
    .instruction_ready(instruction_ready),
    .instruction      (instruction),
    .instruction_pc   (instruction_pc),
    .fetch_misaligned (fetch_misaligned)
  );

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } req_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } ent_t;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model state
  req_t        pend[$];
  ent_t        mq[$];
  logic [31:0] m_pc;
  logic [31:0] m_held_addr;
  int          m_epoch;
  int          m_held_epoch;
  bit          m_held;
  bit          m_mis;

  // Stimulus knobs (percentages) and one-shot directed events
  int          p_fe, p_rdy, p_dec, p_redir, p_rst, lat_max;
  bit          force_redir;
  bit          force_rst;
  logic [31:0] force_target;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] pick_target();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 3))
      0:       return {r[31:2], 2'b00};
      1:       return r;
      2:       return 32'hFFFF_FFF8;
      default: return 32'h0000_0200 + 32'($urandom_range(0, 15)) * 32'd4;
    endcase
  endfunction

  task automatic model_reset();
    m_pc   = RST_ADDR;
    m_epoch++;
    m_mis  = 1'b0;
    m_held = 1'b0;
    mq.delete();
    pend.delete();
  endtask

  task automatic run_cycles(input int n);
    bit          exp_rv, exp_iv, resp_from_pend, accept, keep;
    logic [31:0] exp_ra;
    int          req_ep;
    req_t        r;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      // Drive this cycle's inputs
      reset             = force_rst || ($urandom_range(0, 99) < p_rst);
      force_rst         = 1'b0;
      fetch_enable      = ($urandom_range(0, 99) < p_fe);
      imem_req_ready    = ($urandom_range(0, 99) < p_rdy);
      instruction_ready = ($urandom_range(0, 99) < p_dec);
      if (force_redir && !reset) begin
        redirect_valid   = 1'b1;
        redirect_address = force_target;
        force_redir      = 1'b0;
      end else begin
        redirect_valid   = !reset && ($urandom_range(0, 99) < p_redir);
        redirect_address = pick_target();
      end
      resp_from_pend = 1'b0;
      imem_resp_valid = 1'b0;
      imem_resp_data  = $urandom;
      if (pend.size() != 0) begin
        if (pend[0].due <= cyc) begin
          resp_from_pend  = 1'b1;
          imem_resp_valid = 1'b1;
          imem_resp_data  = mem_word(pend[0].addr);
        end
      end else if ($urandom_range(0, 99) < 10) begin
        imem_resp_valid = 1'b1;  // stray response with nothing in flight
      end
      #1;
      // Expected outputs from the model
      exp_rv = m_held || (fetch_enable && pend.size() == 0 && mq.size() < DEPTH &&
                          !m_mis && !redirect_valid);
      exp_ra = m_held ? m_held_addr : m_pc;
      exp_iv = (mq.size() != 0);
      check_eq("req_valid", 32'(imem_req_valid), 32'(exp_rv));
      check_eq("req_addr", imem_req_address, exp_ra);
      check_eq("inst_valid", 32'(instruction_valid), 32'(exp_iv));
      check_eq("inst_word", instruction, exp_iv ? mq[0].word : NOP);
      check_eq("inst_pc", instruction_pc, exp_iv ? mq[0].pc : 32'h0);
      check_eq("misaligned", 32'(fetch_misaligned), 32'(m_mis));
      // Advance the model across the clock edge
      if (reset) begin
        model_reset();
      end else begin
        req_ep = m_held ? m_held_epoch : m_epoch;
        accept = exp_rv && imem_req_ready;
        keep   = 1'b0;
        if (resp_from_pend) begin
          r    = pend.pop_front();
          keep = (r.epoch == m_epoch) && !redirect_valid;
        end
        if (exp_iv && instruction_ready && !redirect_valid) begin
          void'(mq.pop_front());
        end
        if (keep) begin
          mq.push_back('{r.addr, mem_word(r.addr)});
        end
        if (accept) begin
          pend.push_back('{exp_ra, req_ep, cyc + 1 + $urandom_range(0, lat_max - 1)});
          if (req_ep == m_epoch) m_pc = m_pc + 32'd4;
        end
        m_held       = exp_rv && !imem_req_ready;
        m_held_addr  = exp_ra;
        m_held_epoch = req_ep;
        if (redirect_valid) begin
          mq.delete();
          m_pc  = redirect_address;
          m_mis = |redirect_address[1:0];
          m_epoch++;
        end
      end
      cyc++;
    end
  endtask

  task automatic set_knobs(input int fe, input int rdy, input int dec,
                           input int redir, input int rst, input int lat);
    p_fe = fe; p_rdy = rdy; p_dec = dec; p_redir = redir; p_rst = rst; lat_max = lat;
  endtask

  initial begin
    reset = 1'b1; fetch_enable = 1'b0; redirect_valid = 1'b0; redirect_address = '0;
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
    instruction_ready = 1'b0;
    force_redir = 1'b0; force_rst = 1'b0; force_target = '0;
    m_epoch = 0; m_held_epoch = 0; m_held_addr = '0;
    model_reset();
    repeat (2) @(posedge clk);

    // Reset values held while reset stays high
    set_knobs(100, 100, 100, 0, 100, 1);
    run_cycles(3);

    // Sequential fetch with 1-cycle memory and free-flowing decode
    set_knobs(100, 100, 100, 0, 0, 1);
    run_cycles(40);

    // Backpressure: queue fills to DEPTH and requests stop, then drains
    set_knobs(100, 100, 0, 0, 0, 1);
    run_cycles(20);
    set_knobs(100, 100, 100, 0, 0, 1);
    run_cycles(20);

    // Redirect right after an acceptance and while a request is parked
    set_knobs(100, 100, 100, 0, 0, 2);
    force_redir = 1'b1; force_target = 32'h0000_0200;
    run_cycles(12);
    set_knobs(100, 0, 100, 0, 0, 1);
    run_cycles(2);
    force_redir = 1'b1; force_target = 32'h0000_0280;
    run_cycles(3);
    set_knobs(100, 100, 100, 0, 0, 1);
    run_cycles(10);

    // Misaligned redirect stalls fetching until an aligned redirect
    force_redir = 1'b1; force_target = 32'h0000_0202;
    run_cycles(12);
    force_redir = 1'b1; force_target = 32'h0000_0300;
    run_cycles(12);

    // PC wrap past the top of the address space
    force_redir = 1'b1; force_target = 32'hFFFF_FFF8;
    run_cycles(12);

    // Reset while the queue holds entries and a response is arriving
    set_knobs(100, 100, 0, 0, 0, 1);
    run_cycles(6);
    force_rst = 1'b1;
    run_cycles(1);
    set_knobs(100, 100, 100, 0, 0, 1);
    run_cycles(10);

    // Fully random traffic, then a heavily backpressured variant
    set_knobs(80, 60, 60, 8, 1, 3);
    run_cycles(3000);
    set_knobs(90, 70, 20, 5, 1, 2);
    run_cycles(2000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instruction_fetch_queue.md
# instruction_fetch_queue

- Front-end fetch stage directly upstream of the instruction decoder / control unit pair.
- Issues word fetches to instruction memory over a valid/ready request channel and buffers returned words with their PCs in a small in-order queue.
- Presents one instruction per cycle to decode through a valid/ready handshake.
- Gated by the control unit's `fetch_enable`; flushed and redirected by branch/jump targets from the address generator.

## Interface

Parameters:
- `RESET_ADDRESS`, default 32'h0000_0000: PC of the first fetch after reset.
- `DEPTH`, default 4: queue entries; a power of two, at least 2.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `fetch_enable`  in  1  permits issuing new memory requests.
- `redirect_valid`  in  1  a taken branch or jump this cycle.
- `redirect_address`  in  32  target PC.
- `imem_req_valid`  out  1  fetch request.
- `imem_req_ready`  in  1  memory accepts the request.
- `imem_req_address`  out  32  word address of the fetch.
- `imem_resp_valid`  in  1  read data valid. Responses arrive in order, at least 1 cycle after acceptance.
- `imem_resp_data`  in  32  fetched instruction word.
- `instruction_valid`  out  1  queue head is valid.
- `instruction_ready`  in  1  decode consumes the head.
- `instruction`  out  32  head instruction word; 32'h0000_0013 (NOP) when `instruction_valid`=0.
- `instruction_pc`  out  32  PC of the head; 0 when invalid.
- `fetch_misaligned`  out  1  level: last redirect target had bits [1:0] != 0.

## Operation

State:
- `pc`: next fetch address.
- `req_pc`: address of the outstanding request.
- `outstanding`: 1 bit; at most one request is outstanding.
- `drop`: 1 bit; discard the next response.
- Circular queue of {pc, word}, with head/tail pointers and a count of 0..DEPTH.

Requests:
- `imem_req_valid` asserts when all of the following hold: `fetch_enable`=1, `outstanding`=0, count < DEPTH, `fetch_misaligned`=0, and no redirect this cycle.
- Once asserted, valid and address are held stable until `imem_req_ready`=1. Deasserting `fetch_enable` does not withdraw a request already asserted.
- On acceptance: `req_pc`<=`pc`, `pc`<=`pc`+4 (32-bit wrap from FFFF_FFFC to 0000_0000), `outstanding`<=1.

Responses:
- On `imem_resp_valid` with `outstanding`=1:
  - `outstanding`<=0.
  - If `drop`=1: discard the word and clear `drop`.
  - Otherwise: push {`req_pc`, `imem_resp_data`}.
- A response with `outstanding`=0 is ignored.

Decode handshake:
- Pop when `instruction_valid` and `instruction_ready` are both 1.
- Push and pop in the same cycle leave the count unchanged, including when full.
- A push is never attempted while full: the request gating guarantees a free slot.

Redirect (`redirect_valid`=1):
- Flush the queue: count<=0, head<=tail.
- Any same-cycle pop is void, and any same-cycle response is discarded.
- `pc`<=`redirect_address`.
- If a request is still outstanding after this cycle, set `drop`. This covers both a request accepted in this cycle and an older request not responding in this cycle.
- A request asserted but not yet accepted stays on the bus unchanged until accepted; `drop` is set so its response is discarded.
- If `redirect_address`[1:0] != 0:
  - `fetch_misaligned`<=1 and no further requests are issued.
  - The flag clears only on an aligned redirect or on reset.

Reset:
- Applies whenever `reset`=1, including mid-transaction.
- `pc`=`RESET_ADDRESS`; `outstanding`, `drop`, count, pointers and `fetch_misaligned` all 0.
- A response to a request issued before reset is ignored, because `outstanding`=0.

## Timing

- Reset values: `imem_req_valid`=0, `imem_req_address`=`RESET_ADDRESS`, `instruction_valid`=0, `instruction`=32'h0000_0013, `instruction_pc`=0, `fetch_misaligned`=0.
- First request: `imem_req_valid` rises in the first cycle after `reset` falls, if `fetch_enable`=1.
- Response in cycle N: `instruction_valid` is 1 in cycle N+1. No combinational path from `imem_resp_*` to the decode outputs.
- Redirect in cycle N: `instruction_valid`=0 in N+1. A new request at `redirect_address` appears in N+1 if nothing is outstanding; otherwise in the cycle after the dropped response.
- Throughput: one instruction per 2 cycles with a 1-cycle-latency memory, given the single outstanding request.
- `instruction_ready` affects only the queue. There is no combinational path from `instruction_ready` to `imem_req_valid`.

## Test plan

- Sequential fetch: `RESET_ADDRESS`=0x100, memory ready=1, 1-cycle latency, decode ready=1 -> `instruction_pc` sequence 0x100, 0x104, 0x108, …, each carrying the matching memory word, no gaps beyond the 2-cycle cadence.
- Backpressure: hold `instruction_ready`=0 -> exactly DEPTH (4) entries fill, `imem_req_valid` stays 0. Release -> entries 0x100..0x10C drain in order, then fetching resumes at 0x110.
- Redirect with outstanding request: redirect to 0x200 in the cycle after acceptance of 0x108 -> 0x108's word never appears at decode, and the next `instruction_pc` is 0x200.
- Redirect while request unaccepted (`imem_req_ready`=0) -> `imem_req_address` stays at the old PC until accepted, its response is discarded, and the following request is 0x200.
- Misaligned redirect to 0x202 -> `fetch_misaligned`=1 and no requests. A later redirect to 0x300 clears the flag and fetches 0x300.
- Reset asserted mid-response with the queue holding 3 entries -> next cycle `instruction_valid`=0, count 0, and the first request after release is at `RESET_ADDRESS`.
